// File: rtl/sdram_tester_pkg.sv
// Shared types and constants for the SDRAM Avalon tester.
// State encoding, LFSR taps and the default pattern seed.
package sdram_tester_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // Fibonacci taps 16,14,13,11 as a mask over bits [15:0]
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hA5A5;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sdram_tester_pattern_gen.sv
// Test pattern source; `pattern` is the value for the element selected after this cycle's update.
// SDRAM_TESTER_LFSR_EN selects a 16-bit LFSR stream instead of the address-XOR pattern.
module sdram_tester_pattern_gen
    import sdram_tester_pkg::*;
#(
    parameter int          AW     = 23,
    parameter int          DATA_W = 16,
    parameter logic [15:0] SEED   = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              advance,
    input  logic [AW-1:0]     addr,
    output logic [DATA_W-1:0] pattern
);

`ifdef SDRAM_TESTER_LFSR_EN
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        unused_addr;

    assign unused_addr = ^addr;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load)
            lfsr_d = SEED_NZ;
        else if (advance)
            lfsr_d = lfsr_step(lfsr_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            lfsr_q <= SEED_NZ;
        else
            lfsr_q <= lfsr_d;
    end

    assign pattern = DATA_W'(lfsr_d);
`else
    logic unused_ctl;

    assign unused_ctl = ^{clk, reset_n, load, advance, addr};
    assign pattern    = DATA_W'(16'(addr) ^ SEED);
`endif

endmodule

// File: rtl/sdram_avalon_tester.sv
// Write/read-back tester driving the SDRAM controller az_*/za_* slave port.
// Define SDRAM_TESTER_LFSR_EN for an LFSR data pattern instead of address XOR seed.
module sdram_avalon_tester
    import sdram_tester_pkg::*;
#(
    parameter int          ADDR_W          = 22,
    parameter int          DATA_W          = 16,
    parameter int          NUM_WORDS       = 1024,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [15:0] SEED            = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       error_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [ADDR_W-1:0] az_addr,
    output logic [1:0]        az_be_n,
    output logic              az_cs,
    output logic [DATA_W-1:0] az_data,
    output logic              az_rd_n,
    output logic              az_wr_n,
    input  logic [DATA_W-1:0] za_data,
    input  logic              za_valid,
    input  logic              za_waitrequest
);

    localparam int            CW      = ADDR_W + 1;
    localparam logic [CW-1:0] LAST    = CW'(NUM_WORDS - 1);
    localparam logic [3:0]    MAX_OUT = 4'(MAX_OUTSTANDING);

    state_t state_q, state_d;

    logic [CW-1:0]     wa_q, wa_d, ra_q, ra_d, ca_q, ca_d;
    logic [3:0]        out_q, out_d;
    logic [DATA_W-1:0] exp_q, wpat, cpat;
    logic              go, wr_acc, rd_acc, wr_last, rd_last, rsp, mismatch;

    logic              cs_d, rd_n_d, wr_n_d, busy_d, done_d, pass_d;
    logic [1:0]        be_n_d;
    logic [ADDR_W-1:0] addr_d, ffa_d;
    logic [DATA_W-1:0] data_d;
    logic [15:0]       err_d;

    assign go       = ((state_q == IDLE) || (state_q == DONE)) && start;
    assign wr_acc   = az_cs && !az_wr_n && !za_waitrequest;
    assign rd_acc   = az_cs && !az_rd_n && !za_waitrequest;
    assign wr_last  = wr_acc && (wa_q == LAST);
    assign rd_last  = rd_acc && (ra_q == LAST);
    // Returns with nothing in flight are stale (e.g. after reset) and dropped
    assign rsp      = za_valid && (out_q != 4'd0);
    assign mismatch = rsp && (za_data != exp_q);

    always_comb begin
        wa_d  = go ? '0 : (wr_acc ? wa_q + 1'b1 : wa_q);
        ra_d  = wr_last ? '0 : (rd_acc ? ra_q + 1'b1 : ra_q);
        ca_d  = wr_last ? '0 : (rsp ? ca_q + 1'b1 : ca_q);
        out_d = out_q + {3'b000, rd_acc} - {3'b000, rsp};
    end

    sdram_tester_pattern_gen #(
        .AW     (CW),
        .DATA_W (DATA_W),
        .SEED   (SEED)
    ) u_wr_pat (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (go),
        .advance (wr_acc),
        .addr    (wa_d),
        .pattern (wpat)
    );

    sdram_tester_pattern_gen #(
        .AW     (CW),
        .DATA_W (DATA_W),
        .SEED   (SEED)
    ) u_chk_pat (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (wr_last),
        .advance (rsp),
        .addr    (ca_d),
        .pattern (cpat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start)
                    state_d = WRITE;
                else
                    state_d = IDLE;
            end
            WRITE: if (wr_last) state_d = READ;
            READ:  if (rd_last) state_d = DRAIN;
            DRAIN: if (out_d == 4'd0) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cs_d   = az_cs;
        rd_n_d = az_rd_n;
        wr_n_d = az_wr_n;
        be_n_d = az_be_n;
        addr_d = az_addr;
        data_d = az_data;
        // A presented request is frozen until the slave takes it
        if (!(az_cs && za_waitrequest)) begin
            cs_d   = 1'b0;
            rd_n_d = 1'b1;
            wr_n_d = 1'b1;
            be_n_d = 2'b11;
            if (state_d == WRITE) begin
                cs_d   = 1'b1;
                wr_n_d = 1'b0;
                be_n_d = 2'b00;
                addr_d = wa_d[ADDR_W-1:0];
                data_d = wpat;
            end else if ((state_d == READ) && (out_d < MAX_OUT)) begin
                cs_d   = 1'b1;
                rd_n_d = 1'b0;
                be_n_d = 2'b00;
                addr_d = ra_d[ADDR_W-1:0];
            end
        end

        busy_d = (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
        done_d = done;
        pass_d = pass;
        err_d  = error_count;
        ffa_d  = first_fail_addr;
        if (go) begin
            done_d = 1'b0;
            pass_d = 1'b0;
            err_d  = '0;
            ffa_d  = '0;
        end else begin
            if (mismatch) begin
                if (error_count != 16'hFFFF)
                    err_d = error_count + 1'b1;
                if (error_count == 16'h0000)
                    ffa_d = ca_q[ADDR_W-1:0];
            end
            if ((state_q == DRAIN) && (state_d == DONE)) begin
                done_d = 1'b1;
                pass_d = (err_d == 16'h0000);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wa_q            <= '0;
            ra_q            <= '0;
            ca_q            <= '0;
            out_q           <= '0;
            exp_q           <= '0;
            az_cs           <= 1'b0;
            az_rd_n         <= 1'b1;
            az_wr_n         <= 1'b1;
            az_be_n         <= 2'b11;
            az_addr         <= '0;
            az_data         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            error_count     <= '0;
            first_fail_addr <= '0;
        end else begin
            wa_q            <= wa_d;
            ra_q            <= ra_d;
            ca_q            <= ca_d;
            out_q           <= out_d;
            exp_q           <= cpat;
            az_cs           <= cs_d;
            az_rd_n         <= rd_n_d;
            az_wr_n         <= wr_n_d;
            az_be_n         <= be_n_d;
            az_addr         <= addr_d;
            az_data         <= data_d;
            busy            <= busy_d;
            done            <= done_d;
            pass            <= pass_d;
            error_count     <= err_d;
            first_fail_addr <= ffa_d;
        end
    end

endmodule

// File: doc/sdram_avalon_tester.md
# sdram_avalon_tester

Synthesizable Avalon-style initiator that exercises the SDRAM controller's `az_*`/`za_*` slave port in hardware, replacing the bench-only write/read tasks.
- On `start`, writes a deterministic pattern to `NUM_WORDS` consecutive addresses, then reads them back with pipelined reads, and compares each returned word.
- Reports pass/fail, error count and first failing address.
- Sits between board control logic (KEY/LED or a CSR) and the SDRAM controller, on the controller clock.

## Interface
Parameters:
- `ADDR_W`, 22, controller word-address width
- `DATA_W`, 16, data width (fixed at 16 when the LFSR pattern is compiled in)
- `NUM_WORDS`, 1024, words tested, starting at address 0; range 1..2^ADDR_W
- `MAX_OUTSTANDING`, 4, read requests allowed in flight; range 1..15
- `SEED`, 16'hA5A5, pattern seed

Ports:
- Clock and reset:
  - `clk` in 1: controller clock; single clock domain
  - `reset_n` in 1: asynchronous, active-low reset
- Control and status:
  - `start` in 1: one-cycle pulse; begins a test when idle
  - `busy` out 1: test in progress
  - `done` out 1: test finished; held until next accepted `start`
  - `pass` out 1: valid while `done`; 1 iff `error_count == 0`
  - `error_count` out 16: mismatching words; saturates at 16'hFFFF
  - `first_fail_addr` out ADDR_W: address of the first mismatch
- Controller slave port:
  - `az_addr` out ADDR_W
  - `az_be_n` out 2
  - `az_cs` out 1
  - `az_data` out DATA_W
  - `az_rd_n` out 1
  - `az_wr_n` out 1
  - `za_data` in DATA_W
  - `za_valid` in 1
  - `za_waitrequest` in 1

## Operation
- **Pattern:** `pat(a) = a[15:0] ^ SEED`.
- **States:**
  - IDLE: `start` → WRITE; address counter cleared; errors cleared; `done` cleared.
  - WRITE:
    - Drives `az_cs=1`, `az_wr_n=0`, `az_be_n=00`, `az_addr=wa`, `az_data=pat(wa)`.
    - A write is accepted on a cycle with `!za_waitrequest`.
    - On accept, `wa++`.
    - After the accept at `wa==NUM_WORDS-1` → READ.
  - READ:
    - Drives `az_rd_n=0`, `az_addr=ra` only while `outstanding < MAX_OUTSTANDING`; otherwise `az_cs=0` and `az_rd_n=1`.
    - A read is accepted as for writes.
    - After the last read is accepted → DRAIN.
  - DRAIN: waits until `outstanding==0` → DONE.
  - DONE: asserts `done` and latches `pass`; returns to IDLE the same cycle. Status stays visible until the next `start`.
- **Read returns:**
  - Returns arrive in order.
  - Each `za_valid` compares `za_data` against `pat(ca)`, then `ca++`.
  - On mismatch: `error_count` saturating increment; `first_fail_addr` loaded only on the first mismatch.
- **Outstanding counter:**
  - +1 on read accept, −1 on `za_valid`; unchanged when both occur in the same cycle.
  - `za_valid` while `outstanding==0` is ignored (no compare, no counter change).
- **Request stability:** address, data and strobes stay stable while `za_waitrequest` is high. A request is never withdrawn before acceptance, except a READ-state request that the outstanding limit blocks before it is presented.
- **Start handling:** `start` while `busy` is ignored.
- **Counter widths:** counters are ADDR_W+1 bits, so `NUM_WORDS = 2^ADDR_W` does not wrap.

## Timing
- **Reset values:**
  - `az_cs=0`, `az_rd_n=1`, `az_wr_n=1`, `az_be_n=11`, `az_addr=0`, `az_data=0`
  - `busy=0`, `done=0`, `pass=0`, `error_count=0`, `first_fail_addr=0`
- All outputs are registered.
- **Latencies:**
  - `start` at edge N → first write request and `busy=1` from edge N+1.
  - With `waitrequest` low, writes are back-to-back, one per cycle.
  - First read request is presented the cycle after the last write accept.
  - `done` rises one cycle after the final `za_valid`; `busy` falls the same cycle.
- **Reset mid-operation:** immediately forces the reset values. Pending read returns after reset release arrive with `outstanding==0` and are ignored.

## Configuration
- `SDRAM_TESTER_LFSR_EN`: pattern becomes a 16-bit Fibonacci LFSR, taps 16,14,13,11.
  - Seeded with `SEED`; a seed of 0 is replaced by 16'h0001.
  - The write LFSR advances once per write accept.
  - A separate check LFSR, reseeded at READ entry, advances once per counted `za_valid`.
- Without the macro: address-XOR pattern; no LFSR registers exist.

## Structure
- **Package `sdram_tester_pkg`:** state enum (IDLE, WRITE, READ, DRAIN, DONE), LFSR tap constant, default seed.
- **Sub-module `sdram_tester_pattern_gen`:**
  - Inputs: `load`, `advance`, `addr`. Output: `pattern`.
  - Instantiated twice: one for the write stream, one for the check stream.
  - Contains the macro-selected implementation.

## Test plan
- **Basic pass:** `NUM_WORDS=4`, zero-wait SDRAM model → writes 0xA5A5, 0xA5A4, 0xA5A7, 0xA5A6 to addresses 0..3; `done=1`, `pass=1`, `error_count=0`.
- **Waitrequest stall:** `za_waitrequest` high for 3 cycles on the write to address 1 → `az_addr`/`az_data` held at 1/0xA5A4 throughout; test still passes.
- **Error injection:** model corrupts the returned word at address 2 → `error_count=1`, `first_fail_addr=2`, `pass=0`.
- **Outstanding limit:** `MAX_OUTSTANDING=2`, 10-cycle read latency → never more than 2 reads accepted ahead of returns; all 4 words checked.
- **Reset mid-WRITE:** `reset_n` low after 2 writes → all outputs return to reset values asynchronously. Subsequent `start` runs a clean pass.
- **Start while busy:** `start` pulsed during READ → ignored; a single `done` pulse sequence results; error counters are not cleared mid-run.
